// File: rtl/roi_peak_locator_pkg.sv
// Shared state encoding and sizing helpers for the ROI peak locator.
// Imported by the interface, the lane tree and the top level.
package peak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pos_bits(input int roi);
        return (roi > 1) ? $clog2(roi) : 1;
    endfunction

endpackage

// File: rtl/roi_peak_locator_if.sv
// Sample stream in, peak result out, for the ROI peak locator.
// master = producer/consumer side, slave = the locator.
interface roi_peak_locator_if
    import peak_pkg::*;
#(
    parameter int ROI_SIZE      = 470,
    parameter int WIDTH         = 28,
    parameter int NUM_PER_CYCLE = 10
) ();
    localparam int PB = pos_bits(ROI_SIZE);

    logic                                  din_valid;
    logic [NUM_PER_CYCLE-1:0][WIDTH-1:0]   din;
    logic                                  din_ready;
    logic signed [WIDTH-1:0]               peak_val;
    logic [PB-1:0]                         peak_row;
    logic [PB-1:0]                         peak_col;
    logic                                  peak_valid;

    modport master (
        output din_valid, din,
        input  din_ready, peak_val, peak_row, peak_col, peak_valid
    );

    modport slave (
        input  din_valid, din,
        output din_ready, peak_val, peak_row, peak_col, peak_valid
    );
endinterface

// File: rtl/roi_peak_locator_tree.sv
// Pipelined signed argmax over the lanes of one beat, one register per level.
// Valid and side-band ride along; needs NUM_PER_CYCLE >= 2.
module max_index_tree
    import peak_pkg::*;
#(
    parameter int NUM_PER_CYCLE = 10,
    parameter int WIDTH         = 28,
    parameter int SB_BITS       = 18
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic                                in_valid,
    input  logic [NUM_PER_CYCLE-1:0][WIDTH-1:0] din,
    input  logic [SB_BITS-1:0]                  in_sb,
    output logic                                out_valid,
    output logic signed [WIDTH-1:0]             out_val,
    output logic [lane_bits(NUM_PER_CYCLE)-1:0] out_lane,
    output logic [SB_BITS-1:0]                  out_sb
);
    localparam int L  = $clog2(NUM_PER_CYCLE);
    localparam int LB = lane_bits(NUM_PER_CYCLE);

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic [LB-1:0]           lane;
    } node_t;

    function automatic int nodes(input int s);
        return (NUM_PER_CYCLE + (1 << s) - 1) >> s;
    endfunction

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int NI = nodes(s);
        localparam int NO = nodes(s + 1);

        node_t [NI-1:0]     src;
        node_t [NO-1:0]     win;
        node_t [NO-1:0]     node_q;
        logic               src_v;
        logic               v_q;
        logic [SB_BITS-1:0] src_sb;
        logic [SB_BITS-1:0] sb_q;

        if (s == 0) begin : g_in
            for (genvar i = 0; i < NI; i++) begin : g_lane
                assign src[i].val  = din[i];
                assign src[i].lane = LB'(i);
            end
            assign src_v  = in_valid;
            assign src_sb = in_sb;
        end else begin : g_chain
            assign src    = g_stage[s-1].node_q;
            assign src_v  = g_stage[s-1].v_q;
            assign src_sb = g_stage[s-1].sb_q;
        end

        for (genvar j = 0; j < NO; j++) begin : g_node
            if (2 * j + 1 < NI) begin : g_cmp
                // Upper child must be strictly greater: lower lane wins ties.
                assign win[j] = ($signed(src[2*j+1].val) > $signed(src[2*j].val))
                              ? src[2*j+1] : src[2*j];
            end else begin : g_fwd
                assign win[j] = src[2*j];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (clk_en) begin
                v_q <= src_v;
            end
        end

        always_ff @(posedge clk) begin
            if (clk_en) begin
                node_q <= win;
                sb_q   <= src_sb;
            end
        end
    end

    assign out_valid = g_stage[L-1].v_q;
    assign out_val   = g_stage[L-1].node_q[0].val;
    assign out_lane  = g_stage[L-1].node_q[0].lane;
    assign out_sb    = g_stage[L-1].sb_q;

endmodule

// File: rtl/roi_peak_locator.sv
// Streaming argmax over one ROI frame; reports value and (row, col).
// FSM, raster counters, running max and result registers.
module roi_peak_locator
    import peak_pkg::*;
#(
    parameter int ROI_SIZE      = 470,
    parameter int WIDTH         = 28,
    parameter int NUM_PER_CYCLE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    roi_peak_locator_if.slave bus
);
    localparam int L  = $clog2(NUM_PER_CYCLE);
    localparam int PB = pos_bits(ROI_SIZE);
    localparam int LB = lane_bits(NUM_PER_CYCLE);
    localparam int DB = $clog2(L + 2);

    localparam logic [PB-1:0] LAST_ROW   = PB'(ROI_SIZE - 1);
    localparam logic [PB-1:0] LAST_COL   = PB'(ROI_SIZE - NUM_PER_CYCLE);
    localparam logic [PB-1:0] STEP       = PB'(NUM_PER_CYCLE);
    localparam logic [DB-1:0] DRAIN_LAST = DB'(L);

    state_t                  state_q;
    state_t                  state_d;
    logic [PB-1:0]           row_q;
    logic [PB-1:0]           col_q;
    logic [DB-1:0]           drain_q;
    logic                    first_q;
    logic                    ready;
    logic                    fire;
    logic                    accept;
    logic                    last_beat;

    logic                    t_valid;
    logic signed [WIDTH-1:0] t_val;
    logic [LB-1:0]           t_lane;
    logic [2*PB-1:0]         t_sb;
    logic [PB-1:0]           t_row;
    logic [PB-1:0]           t_col;

    logic signed [WIDTH-1:0] max_val;
    logic [PB-1:0]           max_row;
    logic [PB-1:0]           max_col;

    assign fire          = bus.din_valid && ready;
    assign accept        = clk_en && fire;
    assign last_beat     = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign bus.din_ready = ready && !rst;
    assign {t_row, t_col} = t_sb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (fire) state_d = last_beat ? DRAIN : ACCUM;
            end
            ACCUM: begin
                ready = 1'b1;
                if (fire && last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
        end else if (clk_en) begin
            if (fire) begin
                if (col_q == LAST_COL) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST_ROW) ? '0 : row_q + PB'(1);
                end else begin
                    col_q <= col_q + STEP;
                end
            end
            drain_q <= (state_q == DRAIN) ? drain_q + DB'(1) : '0;
        end
    end

    max_index_tree #(
        .NUM_PER_CYCLE (NUM_PER_CYCLE),
        .WIDTH         (WIDTH),
        .SB_BITS       (2 * PB)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in_valid  (fire),
        .din       (bus.din),
        .in_sb     ({row_q, col_q}),
        .out_valid (t_valid),
        .out_val   (t_val),
        .out_lane  (t_lane),
        .out_sb    (t_sb)
    );

    // First tree result of a frame loads unconditionally, later ones only if larger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b0;
            max_val <= '0;
            max_row <= '0;
            max_col <= '0;
        end else if (clk_en) begin
            if (accept && state_q == IDLE) begin
                first_q <= 1'b1;
            end else if (t_valid) begin
                first_q <= 1'b0;
            end
            if (t_valid && (first_q || t_val > max_val)) begin
                max_val <= t_val;
                max_row <= t_row;
                max_col <= t_col + PB'(t_lane);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.peak_val   <= '0;
            bus.peak_row   <= '0;
            bus.peak_col   <= '0;
            bus.peak_valid <= 1'b0;
        end else if (clk_en) begin
            bus.peak_valid <= (state_q == DONE);
            if (state_q == DONE) begin
                bus.peak_val <= max_val;
                bus.peak_row <= max_row;
                bus.peak_col <= max_col;
            end
        end
    end

endmodule

// File: tb/tb_roi_peak_locator.sv
// Directed bench for roi_peak_locator on a 40x40 frame with 10 lanes.
// Covers reset, peaks, ties, extremes, jitter, reset abort and frame gaps.
module tb_roi_peak_locator;
    localparam int ROI = 40;
    localparam int W   = 28;
    localparam int N   = 10;
    localparam int L   = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int en_edges = 0;
    int pulses = 0;
    int lowrun = 0;
    int last_lowrun = 0;
    int last_k = 0;
    int first_k = 0;
    logic pv_prev = 1'b0;

    int cap_val [16];
    int cap_row [16];
    int cap_col [16];
    int cap_edge[16];
    int cap_gap [16];

    logic signed [W-1:0] img [ROI][ROI];

    roi_peak_locator_if #(
        .ROI_SIZE(ROI), .WIDTH(W), .NUM_PER_CYCLE(N)
    ) bus ();

    roi_peak_locator #(
        .ROI_SIZE(ROI), .WIDTH(W), .NUM_PER_CYCLE(N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (clk_en && !rst) en_edges++;
        #2;
        if (!rst && !bus.din_ready) begin
            lowrun++;
        end else begin
            if (lowrun > 0) last_lowrun = lowrun;
            lowrun = 0;
        end
        if (bus.peak_valid && !pv_prev && pulses < 16) begin
            cap_val[pulses]  = int'($signed(bus.peak_val));
            cap_row[pulses]  = int'(bus.peak_row);
            cap_col[pulses]  = int'(bus.peak_col);
            cap_edge[pulses] = en_edges;
            cap_gap[pulses]  = last_lowrun;
            pulses++;
        end
        pv_prev = bus.peak_valid;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit jit);
        @(negedge clk);
        clk_en = jit ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic fill(input logic signed [W-1:0] v);
        for (int r = 0; r < ROI; r++)
            for (int c = 0; c < ROI; c++)
                img[r][c] = v;
    endtask

    task automatic send_frame(input bit jit, input int rows);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ROI; c += N) begin
                int n;
                if (jit) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.din_valid = 1'b0;
                        tick(jit);
                    end
                end
                for (int l = 0; l < N; l++) bus.din[l] = img[r][c+l];
                bus.din_valid = 1'b1;
                n = 0;
                while (!(clk_en && bus.din_ready) && n < 200) begin
                    tick(jit);
                    n++;
                end
                if (n >= 200) chk("accept_timeout", n, 0);
                tick(jit);
                last_k = en_edges;
                if (r == 0 && c == 0) first_k = en_edges;
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_pulse(input bit jit, input int target);
        int n = 0;
        while (pulses < target && n < 300) begin
            tick(jit);
            n++;
        end
        chk("pulse_arrived", int'(pulses >= target), 1);
    endtask

    initial begin
        int k1;
        int gr;
        int gc;
        logic signed [W-1:0] gv;

        bus.din_valid = 1'b0;
        bus.din       = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.din_ready), 0);
        chk("rst_valid", int'(bus.peak_valid), 0);
        chk("rst_val",   int'($signed(bus.peak_val)), 0);
        chk("rst_row",   int'(bus.peak_row), 0);
        chk("rst_col",   int'(bus.peak_col), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(bus.din_ready), 1);
        tick(0);

        // single peak, then freeze the strobe with clk_en low
        fill('0);
        img[3][27] = 28'sd1000;
        send_frame(0, ROI);
        wait_pulse(0, 1);
        chk("single_val", cap_val[0], 1000);
        chk("single_row", cap_row[0], 3);
        chk("single_col", cap_col[0], 27);
        chk("single_latency", cap_edge[0] - last_k, L + 2);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("freeze_hold", int'(bus.peak_valid), 1);
        clk_en = 1'b1;
        @(negedge clk);
        chk("pulse_drop", int'(bus.peak_valid), 0);

        // ties across beats and rows
        fill('0);
        img[0][9]  = 28'sd5;
        img[0][10] = 28'sd5;
        img[20][0] = 28'sd5;
        send_frame(0, ROI);
        wait_pulse(0, 2);
        chk("tie_val", cap_val[1], 5);
        chk("tie_row", cap_row[1], 0);
        chk("tie_col", cap_col[1], 9);

        // ties inside one beat
        fill('0);
        img[5][14] = 28'sd7;
        img[5][16] = 28'sd7;
        img[5][17] = 28'sd7;
        send_frame(0, ROI);
        wait_pulse(0, 3);
        chk("lane_tie_val", cap_val[2], 7);
        chk("lane_tie_row", cap_row[2], 5);
        chk("lane_tie_col", cap_col[2], 14);

        // all most-negative
        fill(28'sh8000000);
        send_frame(0, ROI);
        wait_pulse(0, 4);
        chk("min_val", cap_val[3], -134217728);
        chk("min_row", cap_row[3], 0);
        chk("min_col", cap_col[3], 0);

        // all -3 with -2 in the last sample
        fill(-28'sd3);
        img[39][39] = -28'sd2;
        send_frame(0, ROI);
        wait_pulse(0, 5);
        chk("last_val", cap_val[4], -2);
        chk("last_row", cap_row[4], 39);
        chk("last_col", cap_col[4], 39);

        // random frame with valid gaps and clk_en drops
        for (int r = 0; r < ROI; r++)
            for (int c = 0; c < ROI; c++)
                img[r][c] = W'($urandom_range(0, 200)) - 28'sd100;
        gv = img[0][0];
        gr = 0;
        gc = 0;
        for (int r = 0; r < ROI; r++)
            for (int c = 0; c < ROI; c++)
                if (img[r][c] > gv) begin
                    gv = img[r][c];
                    gr = r;
                    gc = c;
                end
        send_frame(1, ROI);
        wait_pulse(1, 6);
        chk("rand_val", cap_val[5], int'(gv));
        chk("rand_row", cap_row[5], gr);
        chk("rand_col", cap_col[5], gc);
        chk("rand_latency", cap_edge[5] - last_k, L + 2);
        clk_en = 1'b1;
        tick(0);

        // reset in the middle of frame A, then frame B
        fill('0);
        img[2][2] = 28'sd500;
        send_frame(0, 10);
        rst = 1'b1;
        tick(0);
        tick(0);
        chk("mid_rst_ready", int'(bus.din_ready), 0);
        chk("mid_rst_val", int'($signed(bus.peak_val)), 0);
        chk("mid_rst_row", int'(bus.peak_row), 0);
        chk("mid_rst_col", int'(bus.peak_col), 0);
        rst = 1'b0;
        tick(0);
        fill(-28'sd5);
        img[39][39] = -28'sd1;
        send_frame(0, ROI);
        wait_pulse(0, 7);
        repeat (20) tick(0);
        chk("abort_pulses", pulses, 7);
        chk("abort_val", cap_val[6], -1);
        chk("abort_row", cap_row[6], 39);
        chk("abort_col", cap_col[6], 39);

        // back-to-back frames
        fill('0);
        img[10][20] = 28'sd9;
        send_frame(0, ROI);
        k1 = last_k;
        fill('0);
        img[30][5] = 28'sd9;
        send_frame(0, ROI);
        wait_pulse(0, 9);
        chk("b2b_a_val", cap_val[7], 9);
        chk("b2b_a_row", cap_row[7], 10);
        chk("b2b_a_col", cap_col[7], 20);
        chk("b2b_b_row", cap_row[8], 30);
        chk("b2b_b_col", cap_col[8], 5);
        chk("b2b_ready_low", cap_gap[7], L + 2);
        chk("b2b_first_accept", first_k - k1, L + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
